control_unit: RTL and testbench

Multicycle instruction sequencer for the 16-bit Tron core. It latches each fetched instruction word, decodes it, and drives every control input of the datapath: register addresses, ALU/shift/bus selects, immediate, and the write and PC strobes. It sits between instruction memory and the datapath, and is the consumer side of the datapath's control interface.

---
 rtl/control_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multicycle instruction sequencer for the 16-bit Tron core: latches the fetched
// word, decodes it, and drives the datapath control inputs and PC strobes.
module control_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr,
  input  logic             memReady,
  output logic [7:0]       instructionOp,
  output logic [WIDTH-1:0] immediate,
  output logic [3:0]       regAddA,
  output logic [3:0]       regAddB,
  output logic [3:0]       ALUOp,
  output logic [1:0]       shiftOp,
  output logic [2:0]       busOp,
  output logic             immMUX,
  output logic             regWrite,
  output logic             memWrite,
  output logic             pcAdd,
  output logic             pcJump,
  output logic             pcBranch,
  output logic [3:0]       flagOp,
  output logic             illegal
);

  // state  | meaning
  // FETCH  | wait for memReady, latch instr into IR
  // DECODE | decoded fields settle, no strobes
  // EXEC   | main action strobes for the instruction
  // MEM    | LOAD write-back from data memory
  // JUMP   | JAL target jump after the link write
  typedef enum logic [2:0] {
    stateFetch,
    stateDecode,
    stateExec,
    stateMem,
    stateJump
  } state_t;

  typedef enum logic [3:0] {
    kindAlu,
    kindCmp,
    kindStor,
    kindLoad,
    kindBranch,
    kindJal,
    kindJcond,
    kindNop,
    kindIllegal
  } kind_t;

  state_t          state;
  kind_t           kind;
  logic [WIDTH-1:0] ir;
  logic [3:0]      op;
  logic [3:0]      ext;

  assign op            = ir[15:12];
  assign ext           = ir[7:4];
  assign instructionOp = {op, ext};
  assign regAddA       = ir[3:0];
  assign regAddB       = ir[11:8];
  assign flagOp        = ir[11:8];
  assign shiftOp       = 2'b00;

  always_comb begin
    kind      = kindIllegal;
    immediate = '0;
    ALUOp     = 4'b0000;
    busOp     = 3'd0;
    immMUX    = 1'b0;
    case (op)
      4'b0000: begin
        case (ext)
          4'b0101, 4'b1001, 4'b0001, 4'b0010, 4'b0011: begin
            kind  = kindAlu;
            ALUOp = ext;
            busOp = 3'd2;
          end
          4'b1011: begin
            kind  = kindCmp;
            ALUOp = ext;
            busOp = 3'd2;
          end
          4'b1101: begin
            kind  = kindAlu;
            ALUOp = ext;
          end
          4'b0000: kind = kindNop;
          default: kind = kindIllegal;
        endcase
      end
      4'b0101, 4'b1001, 4'b1011, 4'b1101: begin
        kind      = (op == 4'b1011) ? kindCmp : kindAlu;
        ALUOp     = op;
        immMUX    = 1'b1;
        immediate = {{(WIDTH-8){ir[7]}}, ir[7:0]};
        busOp     = (op == 4'b1101) ? 3'd0 : 3'd2;
      end
      4'b0001, 4'b0010, 4'b0011: begin
        kind      = kindAlu;
        ALUOp     = op;
        immMUX    = 1'b1;
        immediate = {{(WIDTH-8){1'b0}}, ir[7:0]};
        busOp     = 3'd2;
      end
      4'b1111: begin
        kind      = kindAlu;
        ALUOp     = op;
        immMUX    = 1'b1;
        immediate = {ir[7:0], {(WIDTH-8){1'b0}}};
      end
      4'b1000: begin
        case (ext)
          4'b0100: begin
            kind  = kindAlu;
            busOp = 3'd3;
          end
          4'b0000, 4'b0001: begin
            kind      = kindAlu;
            busOp     = 3'd3;
            immMUX    = 1'b1;
            immediate = {{(WIDTH-5){ir[4]}}, ir[4:0]};
          end
          default: kind = kindIllegal;
        endcase
      end
      4'b0100: begin
        case (ext)
          4'b0000: begin
            kind  = kindLoad;
            busOp = 3'd1;
          end
          4'b0100: kind = kindStor;
          4'b1000: begin
            kind  = kindJal;
            busOp = 3'd4;
          end
          4'b1100: kind = kindJcond;
          default: kind = kindIllegal;
        endcase
      end
      4'b1100: begin
        kind      = kindBranch;
        immediate = {{(WIDTH-8){ir[7]}}, ir[7:0]};
      end
      default: kind = kindIllegal;
    endcase
  end

  // Strobes are registered for the state being entered, so each is a clean
  // flop output for exactly one cycle and reset clears them asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= stateFetch;
      ir       <= '0;
      regWrite <= 1'b0;
      memWrite <= 1'b0;
      pcAdd    <= 1'b0;
      pcJump   <= 1'b0;
      pcBranch <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      memWrite <= 1'b0;
      pcAdd    <= 1'b0;
      pcJump   <= 1'b0;
      pcBranch <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        stateFetch: begin
          if (memReady) begin
            ir    <= instr;
            state <= stateDecode;
          end
        end
        stateDecode: begin
          state <= stateExec;
          case (kind)
            kindAlu: begin
              regWrite <= 1'b1;
              pcAdd    <= 1'b1;
            end
            kindCmp: pcAdd <= 1'b1;
            kindStor: begin
              memWrite <= 1'b1;
              pcAdd    <= 1'b1;
            end
            kindLoad:   ;
            kindBranch: pcBranch <= 1'b1;
            kindJal:    regWrite <= 1'b1;
            kindJcond:  pcJump   <= 1'b1;
            kindNop:    pcAdd    <= 1'b1;
            default: begin
              pcAdd   <= 1'b1;
              illegal <= 1'b1;
            end
          endcase
        end
        stateExec: begin
          if (kind == kindLoad) begin
            state    <= stateMem;
            regWrite <= 1'b1;
            pcAdd    <= 1'b1;
          end else if (kind == kindJal) begin
            state  <= stateJump;
            pcJump <= 1'b1;
          end else begin
            state <= stateFetch;
          end
        end
        stateMem:  state <= stateFetch;
        stateJump: state <= stateFetch;
        default:   state <= stateFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, stall, each instruction class,
// immediate extension and mid-instruction reset, sampled on the falling edge.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        memReady;
  logic [7:0]  instructionOp;
  logic [15:0] immediate;
  logic [3:0]  regAddA, regAddB, ALUOp, flagOp;
  logic [1:0]  shiftOp;
  logic [2:0]  busOp;
  logic        immMUX, regWrite, memWrite, pcAdd, pcJump, pcBranch, illegal;
  logic [5:0]  strobes;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] RW   = 6'b100000;
  localparam logic [5:0] MW   = 6'b010000;
  localparam logic [5:0] PA   = 6'b001000;
  localparam logic [5:0] PJ   = 6'b000100;
  localparam logic [5:0] PB   = 6'b000010;
  localparam logic [5:0] IL   = 6'b000001;

  control_unit #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .memReady(memReady),
    .instructionOp(instructionOp), .immediate(immediate),
    .regAddA(regAddA), .regAddB(regAddB), .ALUOp(ALUOp), .shiftOp(shiftOp),
    .busOp(busOp), .immMUX(immMUX), .regWrite(regWrite), .memWrite(memWrite),
    .pcAdd(pcAdd), .pcJump(pcJump), .pcBranch(pcBranch), .flagOp(flagOp),
    .illegal(illegal)
  );

  assign strobes = {regWrite, memWrite, pcAdd, pcJump, pcBranch, illegal};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge inside DECODE.
  task automatic issue(input logic [15:0] w);
    instr    = w;
    memReady = 1'b1;
    @(negedge clk);
    memReady = 1'b0;
    instr    = 16'hDEAD;
  endtask

  initial begin
    reset    = 1'b0;
    memReady = 1'b0;
    instr    = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_strobes", {10'b0, strobes}, {10'b0, NONE});
    chk("rst_imm", immediate, 16'h0000);
    chk("rst_busOp", {13'b0, busOp}, 16'd0);
    chk("rst_ALUOp", {12'b0, ALUOp}, 16'd0);
    chk("rst_immMUX", {15'b0, immMUX}, 16'd0);
    chk("rst_instrOp", {8'b0, instructionOp}, 16'h0000);
    reset = 1'b1;

    // Stall: memReady low, IR must not load and nothing may strobe
    instr = 16'h0351;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_strobes", {10'b0, strobes}, {10'b0, NONE});
      chk("stall_instrOp", {8'b0, instructionOp}, 16'h0000);
    end

    // ADD R1 -> R3
    issue(16'h0351);
    chk("add_dec_strobes", {10'b0, strobes}, {10'b0, NONE});
    chk("add_regAddB", {12'b0, regAddB}, 16'd3);
    chk("add_regAddA", {12'b0, regAddA}, 16'd1);
    chk("add_ALUOp", {12'b0, ALUOp}, 16'h0005);
    chk("add_busOp", {13'b0, busOp}, 16'd2);
    chk("add_immMUX", {15'b0, immMUX}, 16'd0);
    chk("add_instrOp", {8'b0, instructionOp}, 16'h0005);
    @(negedge clk);
    chk("add_exec_strobes", {10'b0, strobes}, {10'b0, RW | PA});
    chk("add_exec_ALUOp", {12'b0, ALUOp}, 16'h0005);
    @(negedge clk);
    chk("add_fetch_strobes", {10'b0, strobes}, {10'b0, NONE});

    // ADDI: sign-extended
    issue(16'h52FF);
    chk("addi_imm", immediate, 16'hFFFF);
    chk("addi_immMUX", {15'b0, immMUX}, 16'd1);
    chk("addi_ALUOp", {12'b0, ALUOp}, 16'h0005);
    chk("addi_busOp", {13'b0, busOp}, 16'd2);
    @(negedge clk);
    chk("addi_exec_strobes", {10'b0, strobes}, {10'b0, RW | PA});
    @(negedge clk);

    // ANDI: zero-extended
    issue(16'h12FF);
    chk("andi_imm", immediate, 16'h00FF);
    chk("andi_immMUX", {15'b0, immMUX}, 16'd1);
    chk("andi_ALUOp", {12'b0, ALUOp}, 16'h0001);
    @(negedge clk);
    chk("andi_exec_strobes", {10'b0, strobes}, {10'b0, RW | PA});
    @(negedge clk);

    // LUI: byte into upper half
    issue(16'hF2AB);
    chk("lui_imm", immediate, 16'hAB00);
    chk("lui_immMUX", {15'b0, immMUX}, 16'd1);
    chk("lui_busOp", {13'b0, busOp}, 16'd0);
    @(negedge clk);
    chk("lui_exec_strobes", {10'b0, strobes}, {10'b0, RW | PA});
    @(negedge clk);

    // CMP: no register write
    issue(16'h03B1);
    @(negedge clk);
    chk("cmp_exec_strobes", {10'b0, strobes}, {10'b0, PA});
    @(negedge clk);

    // LSHI with negative 5-bit amount
    issue(16'h8013);
    chk("lshi_imm", immediate, 16'hFFF3);
    chk("lshi_immMUX", {15'b0, immMUX}, 16'd1);
    chk("lshi_busOp", {13'b0, busOp}, 16'd3);
    chk("lshi_shiftOp", {14'b0, shiftOp}, 16'd0);
    @(negedge clk);
    chk("lshi_exec_strobes", {10'b0, strobes}, {10'b0, RW | PA});
    @(negedge clk);

    // STOR
    issue(16'h4241);
    @(negedge clk);
    chk("stor_exec_strobes", {10'b0, strobes}, {10'b0, MW | PA});
    @(negedge clk);

    // LOAD: 4 cycles, write-back in MEM
    issue(16'h4201);
    chk("load_busOp", {13'b0, busOp}, 16'd1);
    @(negedge clk);
    chk("load_exec_strobes", {10'b0, strobes}, {10'b0, NONE});
    @(negedge clk);
    chk("load_mem_strobes", {10'b0, strobes}, {10'b0, RW | PA});
    chk("load_mem_busOp", {13'b0, busOp}, 16'd1);
    @(negedge clk);
    chk("load_fetch_strobes", {10'b0, strobes}, {10'b0, NONE});

    // JAL: link then jump
    issue(16'h4E83);
    @(negedge clk);
    chk("jal_exec_strobes", {10'b0, strobes}, {10'b0, RW});
    chk("jal_exec_busOp", {13'b0, busOp}, 16'd4);
    @(negedge clk);
    chk("jal_jump_strobes", {10'b0, strobes}, {10'b0, PJ});
    @(negedge clk);
    chk("jal_fetch_strobes", {10'b0, strobes}, {10'b0, NONE});

    // Jcond
    issue(16'h4EC2);
    chk("jcond_immMUX", {15'b0, immMUX}, 16'd0);
    @(negedge clk);
    chk("jcond_exec_strobes", {10'b0, strobes}, {10'b0, PJ});
    @(negedge clk);

    // Bcond
    issue(16'hC0FE);
    chk("bcond_flagOp", {12'b0, flagOp}, 16'd0);
    chk("bcond_imm", immediate, 16'hFFFE);
    @(negedge clk);
    chk("bcond_exec_strobes", {10'b0, strobes}, {10'b0, PB});
    @(negedge clk);
    chk("bcond_fetch_strobes", {10'b0, strobes}, {10'b0, NONE});

    // Illegal opcode
    issue(16'h7000);
    @(negedge clk);
    chk("illegal_exec_strobes", {10'b0, strobes}, {10'b0, IL | PA});
    @(negedge clk);
    chk("illegal_fetch_strobes", {10'b0, strobes}, {10'b0, NONE});

    // Reset mid-EXEC of ADD: strobes drop at once
    issue(16'h0351);
    @(negedge clk);
    chk("rst_mid_exec_strobes", {10'b0, strobes}, {10'b0, RW | PA});
    reset = 1'b0;
    #1;
    chk("rst_mid_drop", {10'b0, strobes}, {10'b0, NONE});
    chk("rst_mid_instrOp", {8'b0, instructionOp}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rel_strobes", {10'b0, strobes}, {10'b0, NONE});
    chk("rst_rel_imm", immediate, 16'h0000);
    chk("rst_rel_busOp", {13'b0, busOp}, 16'd0);

    // After release the FSM must be in FETCH: NOP completes in 3 cycles
    issue(16'h0000);
    chk("nop_dec_strobes", {10'b0, strobes}, {10'b0, NONE});
    @(negedge clk);
    chk("nop_exec_strobes", {10'b0, strobes}, {10'b0, PA});
    @(negedge clk);
    chk("nop_fetch_strobes", {10'b0, strobes}, {10'b0, NONE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
